// File: rtl/mole_spawn_ctrl.sv
// Whack-a-mole spawn controller: pops LFSR-chosen moles on an 8-LED field,
// times gap/up phases in 1 ms ticks and emits one-cycle hit/miss/wrong pulses.
module mole_spawn_ctrl #(
    parameter int unsigned MS_DIV    = 100000,
    parameter int unsigned GAP_MS    = 250,
    parameter int unsigned UP_MS_0   = 1000,
    parameter int unsigned UP_MS_1   = 700,
    parameter int unsigned UP_MS_2   = 450,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable_mole_ctrl,
    input  logic [1:0] difficulty_level,
    input  logic [7:0] hit_btn,
    output logic [7:0] mole_leds,
    output logic [2:0] mole_idx,
    output logic       mole_up,
    output logic       hit_pulse,
    output logic       miss_pulse,
    output logic       wrong_pulse
);

    localparam int unsigned PW = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(MS_DIV - 1);
    localparam logic [10:0]   GAP_LAST  = 11'(GAP_MS - 1);
    localparam logic [10:0]   UP_T0     = 11'(UP_MS_0);
    localparam logic [10:0]   UP_T1     = 11'(UP_MS_1);
    localparam logic [10:0]   UP_T2     = 11'(UP_MS_2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        UP   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [10:0]   ms_q, ms_d;
    logic [10:0]   up_target_q, up_target_d;
    logic [7:0]    mole_leds_q, mole_leds_d;
    logic [2:0]    mole_idx_q, mole_idx_d;
    logic          mole_up_q, mole_up_d;
    logic          hit_q, hit_d;
    logic          miss_q, miss_d;
    logic          wrong_q, wrong_d;

    logic          tick_s;
    logic          gap_end_s;
    logic          up_end_s;
    logic [2:0]    cand_s;
    logic [10:0]   diff_target_s;

    // Phase-end detection, next-hole choice (no immediate repeat) and difficulty lookup
    always_comb begin
        tick_s    = (presc_q == PRESC_MAX);
        gap_end_s = tick_s && (ms_q == GAP_LAST);
        up_end_s  = tick_s && (ms_q == (up_target_q - 11'd1));
        if (lfsr_q[2:0] == mole_idx_q) begin
            cand_s = lfsr_q[2:0] + 3'd1;
        end else begin
            cand_s = lfsr_q[2:0];
        end
        case (difficulty_level)
            2'd0:    diff_target_s = UP_T0;
            2'd1:    diff_target_s = UP_T1;
            default: diff_target_s = UP_T2;
        endcase
    end

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        presc_d     = tick_s ? {PW{1'b0}} : (presc_q + PW'(1));
        ms_d        = tick_s ? (ms_q + 11'd1) : ms_q;
        up_target_d = up_target_q;
        mole_leds_d = mole_leds_q;
        mole_idx_d  = mole_idx_q;
        mole_up_d   = mole_up_q;
        hit_d       = 1'b0;
        miss_d      = 1'b0;
        wrong_d     = 1'b0;

        if (!enable_mole_ctrl) begin
            // Disable silences everything, even a coincident hit or timeout
            state_d     = IDLE;
            presc_d     = {PW{1'b0}};
            ms_d        = 11'd0;
            mole_leds_d = 8'd0;
            mole_up_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = GAP;
                    presc_d = {PW{1'b0}};
                    ms_d    = 11'd0;
                end
                GAP: begin
                    if (gap_end_s) begin
                        state_d     = UP;
                        presc_d     = {PW{1'b0}};
                        ms_d        = 11'd0;
                        mole_idx_d  = cand_s;
                        mole_leds_d = 8'd1 << cand_s;
                        mole_up_d   = 1'b1;
                        up_target_d = diff_target_s;
                    end else begin
                        state_d = GAP;
                    end
                end
                UP: begin
                    if (hit_btn[mole_idx_q] || up_end_s) begin
                        hit_d       = hit_btn[mole_idx_q];
                        miss_d      = !hit_btn[mole_idx_q];
                        state_d     = GAP;
                        presc_d     = {PW{1'b0}};
                        ms_d        = 11'd0;
                        mole_leds_d = 8'd0;
                        mole_up_d   = 1'b0;
                    end else begin
                        wrong_d = |hit_btn;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    mole_leds_d = 8'd0;
                    mole_up_d   = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lfsr_q      <= LFSR_SEED;
            presc_q     <= {PW{1'b0}};
            ms_q        <= 11'd0;
            up_target_q <= UP_T0;
            mole_leds_q <= 8'd0;
            mole_idx_q  <= 3'd0;
            mole_up_q   <= 1'b0;
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
            wrong_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            presc_q     <= presc_d;
            ms_q        <= ms_d;
            up_target_q <= up_target_d;
            mole_leds_q <= mole_leds_d;
            mole_idx_q  <= mole_idx_d;
            mole_up_q   <= mole_up_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
            wrong_q     <= wrong_d;
        end
    end

    assign mole_leds   = mole_leds_q;
    assign mole_idx    = mole_idx_q;
    assign mole_up     = mole_up_q;
    assign hit_pulse   = hit_q;
    assign miss_pulse  = miss_q;
    assign wrong_pulse = wrong_q;

endmodule

// File: tb/tb_mole_spawn_ctrl.sv
// Self-checking bench for mole_spawn_ctrl: cycle scoreboard against a
// cycle-count reference model, a vector table and hand-written timing sequences.
module tb_mole_spawn_ctrl;

    localparam int MS_DIV = 4;
    localparam int GAP_MS = 3;
    localparam int UP0    = 10;
    localparam int UP1    = 7;
    localparam int UP2    = 5;
    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [1:0] diff;
    logic [7:0] btn;
    logic [7:0] mole_leds;
    logic [2:0] mole_idx;
    logic       mole_up, hit_pulse, miss_pulse, wrong_pulse;

    mole_spawn_ctrl #(
        .MS_DIV(MS_DIV), .GAP_MS(GAP_MS), .UP_MS_0(UP0), .UP_MS_1(UP1),
        .UP_MS_2(UP2), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable_mole_ctrl(en), .difficulty_level(diff),
        .hit_btn(btn), .mole_leds(mole_leds), .mole_idx(mole_idx), .mole_up(mole_up),
        .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .wrong_pulse(wrong_pulse)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] leds;
        logic [2:0] idx;
        logic       up;
        logic       hit;
        logic       miss;
        logic       wrong;
    } obs_t;

    typedef struct {
        logic [1:0] diff;
        int         kind;   // 0 none, 1 correct, 2 wrong, 3 correct+wrong
        int         delay;  // idle cycles after the mole lights
        logic       exp_hit;
        logic       exp_miss;
        logic       exp_wrong;
        logic       exp_lit;
    } vec_t;

    obs_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Reference model: single elapsed-cycle counter per phase
    int         m_state;
    int         m_cnt;
    int         m_tgt;
    logic [2:0] m_idx;
    logic [15:0] m_lfsr;
    obs_t       m_out;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_edge();
        logic [15:0] nx;
        logic [2:0]  c;
        nx = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        m_out.hit = 1'b0; m_out.miss = 1'b0; m_out.wrong = 1'b0;
        if (!rst_n) begin
            m_state = 0; m_cnt = 0; m_idx = 3'd0; m_lfsr = SEED; m_tgt = UP0; m_out = '0;
        end else if (!en) begin
            m_state = 0; m_cnt = 0; m_out.leds = 8'd0; m_out.up = 1'b0; m_lfsr = nx;
        end else begin
            case (m_state)
                0: begin m_state = 1; m_cnt = 0; end
                1: begin
                    if (m_cnt == GAP_MS * MS_DIV - 1) begin
                        c = m_lfsr[2:0];
                        if (c == m_idx) c = c + 3'd1;
                        m_idx = c; m_out.leds = 8'd1 << c; m_out.up = 1'b1;
                        m_tgt = (diff == 2'd0) ? UP0 : (diff == 2'd1) ? UP1 : UP2;
                        m_state = 2; m_cnt = 0;
                    end else m_cnt++;
                end
                default: begin
                    if (btn[m_idx]) begin
                        m_out.hit = 1'b1; m_out.leds = 8'd0; m_out.up = 1'b0; m_state = 1; m_cnt = 0;
                    end else if (m_cnt == m_tgt * MS_DIV - 1) begin
                        m_out.miss = 1'b1; m_out.leds = 8'd0; m_out.up = 1'b0; m_state = 1; m_cnt = 0;
                    end else begin
                        if (btn != 8'd0) m_out.wrong = 1'b1;
                        m_cnt++;
                    end
                end
            endcase
            m_lfsr = nx;
        end
        m_out.idx = m_idx;
    endtask

    // One clock: drive inputs, push the model's prediction, compare after the edge
    task automatic step(input logic [7:0] b);
        obs_t got;
        btn = b;
        model_edge();
        exp_q.push_back(m_out);
        @(posedge clk);
        #1;
        btn = 8'd0;
        got = {mole_leds, mole_idx, mole_up, hit_pulse, miss_pulse, wrong_pulse};
        check("cycle", 32'(got), 32'(exp_q.pop_front()));
    endtask

    function automatic logic [7:0] btn_of(input int kind);
        logic [2:0] w;
        w = m_idx + 3'd1;
        case (kind)
            1:       btn_of = 8'd1 << m_idx;
            2:       btn_of = 8'd1 << w;
            3:       btn_of = (8'd1 << m_idx) | (8'd1 << w);
            default: btn_of = 8'd0;
        endcase
    endfunction

    task automatic wait_lit(output int zeros);
        zeros = 0;
        for (int i = 0; i < 200; i++) begin
            if (mole_leds != 8'd0) break;
            zeros++;
            step(8'd0);
        end
        check("wait_lit_bound", 32'(mole_leds != 8'd0), 32'd1);
    endtask

    task automatic count_lit(output int lit);
        lit = 0;
        for (int i = 0; i < 200; i++) begin
            if (mole_leds == 8'd0) break;
            lit++;
            step(8'd0);
        end
        check("count_lit_bound", 32'(mole_leds == 8'd0), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t       vecs[8];
        int         z, lit;
        logic [2:0] prev;
        logic [7:0] seen;

        vecs[0] = '{2'd0, 1, 0,  1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{2'd0, 3, 3,  1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{2'd0, 1, 39, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{2'd0, 2, 10, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{2'd0, 1, 2,  1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{2'd0, 0, 39, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{2'd1, 0, 27, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{2'd3, 0, 19, 1'b0, 1'b1, 1'b0, 1'b0};

        rst_n = 1'b0; en = 1'b0; diff = 2'd0; btn = 8'd0;
        step(8'd0);
        step(8'd0);
        rst_n = 1'b1;
        check("rst_leds", 32'(mole_leds), 32'd0);
        check("rst_idx", 32'(mole_idx), 32'd0);
        check("rst_pulses", 32'({mole_up, hit_pulse, miss_pulse, wrong_pulse}), 32'd0);

        // Enable, full gap then an unhit mole times out after 40 cycles
        en = 1'b1;
        wait_lit(z);
        check("gap_after_enable", 32'(z), 32'd13);
        check("onehot_first", 32'(mole_leds), 32'(8'd1 << mole_idx));
        count_lit(lit);
        check("up_len_d0", 32'(lit), 32'd40);
        check("miss_on_timeout", 32'(miss_pulse), 32'd1);

        // Correct hit a few cycles in, then next mole after 12 dark cycles
        wait_lit(z);
        check("gap_after_miss", 32'(z), 32'd12);
        prev = mole_idx;
        repeat (4) step(8'd0);
        step(btn_of(1));
        check("hit_pulse", 32'(hit_pulse), 32'd1);
        check("hit_leds_off", 32'(mole_leds), 32'd0);
        wait_lit(z);
        check("gap_after_hit", 32'(z), 32'd12);
        check("idx_changed", 32'(mole_idx != prev), 32'd1);

        // Wrong at lit cycle 5, correct at 8
        repeat (5) step(8'd0);
        step(btn_of(2));
        check("wrong_at_6", 32'({hit_pulse, miss_pulse, wrong_pulse}), 32'b001);
        check("still_lit_after_wrong", 32'(mole_leds != 8'd0), 32'd1);
        repeat (2) step(8'd0);
        step(btn_of(1));
        check("hit_at_9", 32'({hit_pulse, miss_pulse, wrong_pulse}), 32'b100);
        step(8'hFF);
        check("gap_press_quiet", 32'({hit_pulse, miss_pulse, wrong_pulse}), 32'd0);

        for (int i = 0; i < 8; i++) begin
            diff = vecs[i].diff;
            wait_lit(z);
            repeat (vecs[i].delay) step(8'd0);
            step(btn_of(vecs[i].kind));
            check("vec_hit", 32'(hit_pulse), 32'(vecs[i].exp_hit));
            check("vec_miss", 32'(miss_pulse), 32'(vecs[i].exp_miss));
            check("vec_wrong", 32'(wrong_pulse), 32'(vecs[i].exp_wrong));
            check("vec_lit", 32'(mole_leds != 8'd0), 32'(vecs[i].exp_lit));
        end

        // Difficulty change mid-mole only affects the next mole
        diff = 2'd2;
        wait_lit(z);
        diff = 2'd0;
        count_lit(lit);
        check("up_len_d2", 32'(lit), 32'd20);
        wait_lit(z);
        count_lit(lit);
        check("up_len_next_d0", 32'(lit), 32'd40);

        // Disable with a coincident correct press
        wait_lit(z);
        repeat (3) step(8'd0);
        prev = mole_idx;
        en = 1'b0;
        step(btn_of(1));
        check("dis_leds", 32'({mole_leds, mole_up}), 32'd0);
        check("dis_pulses", 32'({hit_pulse, miss_pulse, wrong_pulse}), 32'd0);
        check("dis_idx_hold", 32'(mole_idx), 32'(prev));
        step(8'd0);
        en = 1'b1;
        wait_lit(z);
        check("gap_after_reenable", 32'(z), 32'd13);
        // Disable on the timeout edge: no miss
        repeat (39) step(8'd0);
        en = 1'b0;
        step(8'd0);
        check("dis_timeout_quiet", 32'({mole_leds, miss_pulse}), 32'd0);
        // Reset mid-mole with a coincident press
        en = 1'b1;
        wait_lit(z);
        repeat (2) step(8'd0);
        rst_n = 1'b0;
        step(btn_of(1));
        check("rst_mid_outputs",
              32'({mole_leds, mole_idx, mole_up, hit_pulse, miss_pulse, wrong_pulse}), 32'd0);
        rst_n = 1'b1;

        // 200 moles: no repeats, all holes visited
        diff = 2'd2;
        prev = mole_idx;
        seen = 8'd0;
        for (int i = 0; i < 200; i++) begin
            wait_lit(z);
            check("no_repeat", 32'(mole_idx != prev), 32'd1);
            check("onehot", 32'(mole_leds), 32'(8'd1 << mole_idx));
            seen = seen | mole_leds;
            prev = mole_idx;
            repeat (i % 3) step(8'd0);
            step(btn_of(1));
        end
        check("all_holes", 32'(seen), 32'hFF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mole_spawn_ctrl.md
Name: mole_spawn_ctrl

Overview:
Mole controller stage, directly downstream of the game control FSM. It consumes enable_mole_ctrl and difficulty_level from the FSM and button pulses from button_io. It pops pseudo-random moles on an 8-LED field and judges hits. It emits one-cycle hit/miss/wrong pulses that feed the score counter.

Parameters:
MS_DIV, 100000, clock cycles per 1 ms tick (bench uses 4)
GAP_MS, 250, ms with no mole lit between moles
UP_MS_0, 1000, mole up-time at difficulty 0
UP_MS_1, 700, mole up-time at difficulty 1
UP_MS_2, 450, mole up-time at difficulty 2 (also used for 2'b11)
LFSR_SEED, 16'hACE1, LFSR reset value (must be nonzero)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
enable_mole_ctrl  in  1  level; high while game is PLAYING
difficulty_level  in  2  0/1/2, 3 treated as 2
hit_btn  in  8  one-cycle press pulses, bit i = hole i
mole_leds  out  8  one-hot lit mole, 0 when none
mole_idx  out  3  index of current or last mole
mole_up  out  1  high while a mole is lit
hit_pulse  out  1  one cycle, correct hole hit
miss_pulse  out  1  one cycle, mole timed out
wrong_pulse  out  1  one cycle, wrong hole pressed while a mole is up

Behaviour:
- Clocking: one clock domain. Reset is synchronous and active-low on rst_n, sampled at posedge clk.
- Reset values:
  - state IDLE; mole_leds 0, mole_idx 0, mole_up 0, all pulses 0.
  - lfsr = LFSR_SEED; prescaler 0, ms counter 0, up_target = UP_MS_0.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances every cycle in all states except reset, so press timing adds entropy.
- Tick: the prescaler counts 0..MS_DIV-1 in GAP/UP and wraps. A tick occurs in the cycle it equals MS_DIV-1. The ms counter is 11 bits; all *_MS must be ≤ 2047.
- Phase timing:
  - On entering GAP or UP, the prescaler and ms counter clear.
  - The phase ends on the tick where the ms counter reaches target-1.
  - So GAP lasts exactly GAP_MS*MS_DIV cycles, and an unhit mole stays lit exactly up_target*MS_DIV cycles.
- States:
  - IDLE: outputs quiet. If enable_mole_ctrl=1, go to GAP next cycle.
  - GAP: mole_leds=0. At phase end, go to UP and in that same edge:
    - candidate = lfsr[2:0]; if candidate==mole_idx, use candidate+1 mod 8 (no immediate repeats).
    - Set mole_idx=candidate, mole_leds=1<<candidate, mole_up=1.
    - Latch up_target from difficulty_level as sampled at that edge.
  - UP, in priority order:
    1. hit_btn[mole_idx]=1: hit_pulse=1 next cycle, mole_leds=0, go to GAP.
    2. Else phase end: miss_pulse=1 next cycle, mole_leds=0, go to GAP.
    3. Else any other hit_btn bit set: wrong_pulse=1 next cycle, stay in UP, timer unaffected.
  - A correct hit on the same cycle as timeout counts as a hit; no miss.
  - Correct plus wrong bits together count as a hit; no wrong_pulse.
- hit_btn is ignored in IDLE and GAP; no pulses are generated there.
- Latency: every pulse is registered, high exactly one cycle, in the cycle after the causing input or tick. At most one of hit/miss/wrong is high in any cycle.
- Disable: enable_mole_ctrl=0 in any state → next edge is IDLE. mole_leds=0, mole_up=0, counters cleared, and no pulse is generated, even if a hit or timeout coincides. mole_idx holds its value. The LFSR keeps running.
- difficulty_level changes mid-mole take effect only at the next mole.
- Reset mid-operation wins over everything and returns all outputs to their reset values at that edge.

Test Plan:
- MS_DIV=4, GAP_MS=3, UP_MS_0=10, diff 0; raise enable after reset → mole_leds 0 for 1+12 cycles, then one-hot lit for exactly 40 cycles, then miss_pulse high 1 cycle and LEDs 0.
- Same setup, pulse hit_btn[mole_idx] 5 cycles after lighting → hit_pulse high the next cycle, LEDs 0, next mole after 12 cycles with a different idx.
- Pulse a wrong bit at cycle 5, then the correct bit at cycle 8 → wrong_pulse at 6, hit_pulse at 9, no miss.
- Correct hit on the final lit cycle (timeout edge) → hit_pulse only, miss_pulse stays 0. Correct+wrong bits in one pulse → hit_pulse only.
- Diff 2, UP_MS_2=5: lit 20 cycles. Change difficulty to 0 mid-mole → current mole still 20 cycles, next mole 40.
- Drop enable or assert rst_n=0 while a mole is lit → LEDs 0 next edge, no pulses. Run 200 moles and check no two consecutive mole_idx values are equal and all 8 holes occur.
